// File: rtl/alu_pkg.sv
// Shared constants for the ALU: op-code encodings and the default datapath width.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 4;

    localparam logic [1:0] ALU_AND  = 2'b00;
    localparam logic [1:0] ALU_OR   = 2'b01;
    localparam logic [1:0] ALU_ADD  = 2'b10;
    localparam logic [1:0] ALU_NAND = 2'b11;

endpackage

// File: rtl/alu_adder.sv
// Ripple-carry adder built from one full adder per bit. No carry-in.
// Exposes the carry into the MSB so the caller can derive signed overflow.
module alu_adder
    import alu_pkg::*;
#(
    parameter int unsigned width = ALU_WIDTH
) (
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    output logic [width-1:0] sum,
    output logic             cout,
    output logic             cmsb
);

    // c[i] is the carry into bit i; c[0] is tied low.
    logic [width:0] c;

    assign c[0] = 1'b0;

    for (genvar i = 0; i < width; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[width];
    assign cmsb = c[width-1];

endmodule

// File: rtl/alu_4bit.sv
// Registered two-operand ALU: AND, OR, ADD (with carry-out) and NAND.
// Optional feature macro: ALU_OVERFLOW_EN adds a registered signed-overflow output.
module alu_4bit
    import alu_pkg::*;
#(
    parameter int unsigned width = ALU_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [width-1:0] a,
    input  logic signed [width-1:0] b,
    input  logic        [1:0]       sel,
    output logic signed [width-1:0] out,
    output logic                    carry
`ifdef ALU_OVERFLOW_EN
    ,
    output logic                    overflow
`endif
);

    logic [width-1:0] sum;
    logic             cout;
    logic [width-1:0] out_d;
    logic             carry_d;

`ifdef ALU_OVERFLOW_EN
    logic cmsb;
    logic overflow_d;

    alu_adder #(
        .width (width)
    ) u_adder (
        .a    (a),
        .b    (b),
        .sum  (sum),
        .cout (cout),
        .cmsb (cmsb)
    );
`else
    alu_adder #(
        .width (width)
    ) u_adder (
        .a    (a),
        .b    (b),
        .sum  (sum),
        .cout (cout),
        .cmsb ()
    );
`endif

    // Operation mux: select next result and carry from the current operands.
    always_comb begin
        out_d   = '0;
        carry_d = 1'b0;
        unique case (sel)
            ALU_AND:  out_d = a & b;
            ALU_OR:   out_d = a | b;
            ALU_ADD: begin
                out_d   = sum;
                carry_d = cout;
            end
            ALU_NAND: out_d = ~(a & b);
            default:  out_d = '0;
        endcase
    end

`ifdef ALU_OVERFLOW_EN
    // Signed overflow: carry into the MSB differs from carry out of it.
    always_comb begin
        overflow_d = 1'b0;
        if (sel == ALU_ADD) begin
            overflow_d = cmsb ^ cout;
        end
    end
`endif

    // Output registers with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            out   <= '0;
            carry <= 1'b0;
`ifdef ALU_OVERFLOW_EN
            overflow <= 1'b0;
`endif
        end else begin
            out   <= out_d;
            carry <= carry_d;
`ifdef ALU_OVERFLOW_EN
            overflow <= overflow_d;
`endif
        end
    end

endmodule

// File: tb/tb_alu_4bit.sv
// Self-checking bench for alu_4bit. Expected results are queued when stimulus is
// driven and compared one edge later when the registered output is available.
// Overflow is checked only when ALU_OVERFLOW_EN is defined.
module tb_alu_4bit;

    typedef struct packed {
        logic [3:0] out;
        logic       carry;
        logic       ovf;
    } exp_t;

    logic              clk;
    logic              rst;
    logic signed [3:0] a;
    logic signed [3:0] b;
    logic        [1:0] sel;
    logic signed [3:0] out;
    logic              carry;
`ifdef ALU_OVERFLOW_EN
    logic              overflow;
`endif

    exp_t  sb[$];
    string tags[$];
    int    n_checks;
    int    n_pass;

    alu_4bit #(
        .width (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b        (b),
        .sel      (sel),
        .out      (out),
        .carry    (carry)
`ifdef ALU_OVERFLOW_EN
        ,
        .overflow (overflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Reference model written from the operation table, independent of the RTL.
    function automatic exp_t model(input logic r, input logic [3:0] ta, input logic [3:0] tb,
                                   input logic [1:0] ts);
        exp_t       e;
        logic [4:0] s;
        e = '0;
        if (!r) begin
            case (ts)
                2'b00: e.out = ta & tb;
                2'b01: e.out = ta | tb;
                2'b10: begin
                    s       = {1'b0, ta} + {1'b0, tb};
                    e.out   = s[3:0];
                    e.carry = s[4];
                    e.ovf   = (ta[3] == tb[3]) && (s[3] != ta[3]);
                end
                default: e.out = ~(ta & tb);
            endcase
        end
        return e;
    endfunction

    // Drive one cycle of stimulus, queue its expectation, then compare after the edge.
    task automatic step(input logic r, input logic [3:0] ta, input logic [3:0] tb,
                        input logic [1:0] ts, input string tag);
        exp_t  e;
        string t;
        @(negedge clk);
        rst = r;
        a   = ta;
        b   = tb;
        sel = ts;
        sb.push_back(model(r, ta, tb, ts));
        tags.push_back(tag);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        t = tags.pop_front();
        check({t, "_out"}, {4'b0, out}, {4'b0, e.out});
        check({t, "_carry"}, {7'b0, carry}, {7'b0, e.carry});
`ifdef ALU_OVERFLOW_EN
        check({t, "_ovf"}, {7'b0, overflow}, {7'b0, e.ovf});
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b1;
        a   = '0;
        b   = '0;
        sel = 2'b00;

        // Reset with an ADD pending, then release.
        step(1'b1, 4'b1111, 4'b1111, 2'b10, "rst");
        step(1'b0, 4'b1111, 4'b1111, 2'b10, "rst_rel");

        // AND
        step(1'b0, 4'b0011, 4'b0111, 2'b00, "and0");
        step(1'b0, 4'b1011, 4'b0110, 2'b00, "and1");
        step(1'b0, 4'b1111, 4'b0100, 2'b00, "and2");

        // ADD
        step(1'b0, 4'b0011, 4'b0111, 2'b10, "add0");
        step(1'b0, 4'b0001, 4'b0101, 2'b10, "add1");
        step(1'b0, 4'b0010, 4'b1111, 2'b10, "add2");
        step(1'b0, 4'b1011, 4'b0110, 2'b10, "add3");
        step(1'b0, 4'b1111, 4'b0100, 2'b10, "add4");
        step(1'b0, 4'b1000, 4'b1000, 2'b10, "add_negovf");

        // OR
        step(1'b0, 4'b0010, 4'b1111, 2'b01, "or0");
        step(1'b0, 4'b1011, 4'b0011, 2'b01, "or1");
        step(1'b0, 4'b0001, 4'b0101, 2'b01, "or2");

        // NAND
        step(1'b0, 4'b0011, 4'b0111, 2'b11, "nand0");
        step(1'b0, 4'b1111, 4'b0100, 2'b11, "nand1");

        // Back-to-back op switch on consecutive cycles.
        step(1'b0, 4'b0111, 4'b0011, 2'b00, "b2b_and");
        step(1'b0, 4'b0111, 4'b0011, 2'b10, "b2b_add");

        // Reset mid-stream wins over a carrying ADD.
        step(1'b0, 4'b1111, 4'b0001, 2'b10, "pre_rst");
        step(1'b1, 4'b1111, 4'b0001, 2'b10, "mid_rst");
        step(1'b0, 4'b1111, 4'b0001, 2'b10, "post_rst");

        // Random sweep across all ops.
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 2'($urandom_range(0, 3)), $sformatf("rnd%0d", i));
        end

        check("sb_empty", 8'(sb.size()), 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
